// File: rtl/cd_mult_pipe.sv
// Pipelined unsigned A_W x B_W multiplier with an optional carry-disregard mode for the low CD_COLS columns.
// Latency: operands captured into S1 on the input handshake, result registered one edge later (2 stages).
// Backpressure: S2 holds while out_valid & ~out_ready; S1 then fills and in_ready drops; nothing lost.
module cd_mult_pipe #(
    parameter int A_W     = 8,
    parameter int B_W     = 4,
    parameter int CD_COLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_r,
    output logic               out_approx
);
    localparam int W      = A_W + B_W;
    localparam bit HAS_CD = (CD_COLS > 0);

    logic           s1_valid;
    logic [A_W-1:0] s1_a;
    logic [B_W-1:0] s1_b;
    logic           s1_approx;

    logic           s2_load;
    logic           in_fire;
    logic           use_approx;
    logic [W-1:0]   exact_r;
    logic [W-1:0]   approx_r;
    logic [W-1:0]   par;
    logic [W-1:0]   hi;

    assign s2_load    = s1_valid & (~out_valid | out_ready);
    assign in_ready   = ~s1_valid | s2_load;
    assign in_fire    = in_valid & in_ready;
    assign use_approx = HAS_CD & s1_approx;

    assign exact_r = {{B_W{1'b0}}, s1_a} * {{A_W{1'b0}}, s1_b};

    // Low columns keep only the parity of their partial products; every partial
    // product at or above CD_COLS is accumulated at its true weight, so no carry
    // ever crosses from the parity region into the exact region.
    always_comb begin
        par = '0;
        hi  = '0;
        for (int i = 0; i < A_W; i++) begin
            for (int k = 0; k < B_W; k++) begin
                if (i + k < CD_COLS) begin
                    par[i+k] = par[i+k] ^ (s1_a[i] & s1_b[k]);
                end else begin
                    hi = hi + ({{(W-1){1'b0}}, s1_a[i] & s1_b[k]} << (i + k));
                end
            end
        end
        approx_r = hi | par;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_approx <= in_approx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_r      <= '0;
            out_approx <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid  <= 1'b1;
                out_r      <= use_approx ? approx_r : exact_r;
                out_approx <= s1_approx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cd_mult_pipe.sv
// Bench for cd_mult_pipe: directed vectors, backpressure, mid-stream reset and a random sweep,
// with a column-popcount reference model; a CD_COLS=0 instance shares the stimulus.
module tb_cd_mult_pipe;
    localparam int A_W = 8;
    localparam int B_W = 4;
    localparam int W   = A_W + B_W;

    typedef struct {
        logic [W-1:0] r;
        logic         ap;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           in_approx;
    logic           out_ready;

    logic           in_ready,  in_ready0;
    logic           out_valid, out_valid0;
    logic [W-1:0]   out_r,     out_r0;
    logic           out_approx, out_approx0;

    int tests = 0;
    int fails = 0;
    int accepted = 0;
    exp_t q[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    cd_mult_pipe #(.A_W(A_W), .B_W(B_W), .CD_COLS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_approx(out_approx)
    );

    cd_mult_pipe #(.A_W(A_W), .B_W(B_W), .CD_COLS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_r(out_r0), .out_approx(out_approx0)
    );

    // Reference: popcount each result column; parity below cd, weighted sum above.
    function automatic logic [W-1:0] ref_mult(logic [A_W-1:0] a, logic [B_W-1:0] b,
                                               logic ap, int cd);
        int ai = int'(a);
        int bi = int'(b);
        int hi = 0;
        int cnt;
        logic [W-1:0] r = '0;
        if (!ap || cd == 0) return W'(ai * bi);
        for (int j = 0; j < W; j++) begin
            cnt = 0;
            for (int i = 0; i < A_W; i++) begin
                if (j - i >= 0 && j - i < B_W && a[i] && b[j-i]) cnt++;
            end
            if (j < cd) r[j] = cnt[0];
            else        hi  = hi + (cnt << j);
        end
        return r | W'(hi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance one cycle.
    task automatic step(input logic iv, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic ap, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        out_ready = ordy;
        @(negedge clk);
        if (out_valid) begin
            chk("no_stale", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                chk("out_r", 32'(out_r), 32'(q[0].r));
                chk("out_approx", 32'(out_approx), 32'(q[0].ap));
                if (out_ready) void'(q.pop_front());
            end
        end
        if (out_valid0) begin
            chk("no_stale_cd0", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                chk("out_r_cd0", 32'(out_r0), 32'(q0[0].r));
                if (out_ready) void'(q0.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            e.r  = ref_mult(a, b, ap, 4);
            e.ap = ap;
            q.push_back(e);
            accepted++;
        end
        if (in_valid && in_ready0) begin
            e.r  = ref_mult(a, b, ap, 0);
            e.ap = ap;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic ap,
                       input logic [W-1:0] expv, input string tag);
        step(1'b1, a, b, ap, 1'b1);
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_r"}, 32'(out_r), 32'(expv));
        chk({tag, "_ap"}, 32'(out_approx), 32'(ap));
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q.size() > 0 || q0.size() > 0); i++)
            step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_q", 32'(q.size()), 32'd0);
        chk("drain_q0", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        logic [A_W-1:0] xa [4];
        logic [B_W-1:0] xb [4];
        logic           xm [4];
        int cycles;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        chk("rst_out_approx", 32'(out_approx), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        one(8'hFF, 4'hF, 1'b1, 12'hEC5, "T1");
        one(8'hFF, 4'hF, 1'b0, 12'hEF1, "T2a");
        one(8'h03, 4'h3, 1'b0, 12'h009, "T2b");
        one(8'h03, 4'h3, 1'b1, 12'h005, "T3a");
        one(8'h00, 4'hF, 1'b1, 12'h000, "T3b");
        one(8'h00, 4'hF, 1'b0, 12'h000, "T3c");

        // Backpressure: four back-to-back inputs with a three-cycle output stall.
        for (int i = 0; i < 4; i++) begin
            xa[i] = A_W'($urandom);
            xb[i] = B_W'($urandom);
            xm[i] = 1'($urandom);
        end
        step(1'b1, xa[0], xb[0], xm[0], 1'b1);
        step(1'b1, xa[1], xb[1], xm[1], 1'b0);
        in_valid = 1'b1; in_a = xa[2]; in_b = xb[2]; in_approx = xm[2]; out_ready = 1'b0;
        #1;
        chk("T4_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, xa[2], xb[2], xm[2], 1'b0);
        step(1'b1, xa[2], xb[2], xm[2], 1'b0);
        chk("T4_stall_vld", 32'(out_valid), 32'd1);
        step(1'b1, xa[2], xb[2], xm[2], 1'b1);
        step(1'b1, xa[3], xb[3], xm[3], 1'b1);
        chk("T4_accepted", 32'(accepted), 32'd10);
        drain();

        // Reset with both stages occupied; the in_valid during reset must be ignored.
        step(1'b1, 8'h5A, 4'h7, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 4'h9, 1'b0, 1'b0);
        chk("T5_full", 32'(in_ready), 32'd0);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        q.delete();
        q0.delete();
        chk("T5_out_valid", 32'(out_valid), 32'd0);
        chk("T5_out_r", 32'(out_r), 32'd0);
        chk("T5_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'($urandom));

        // Random sweep with random valid, ready and mode.
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            step(1'($urandom_range(0, 3) != 0), A_W'($urandom), B_W'($urandom),
                 1'($urandom), 1'($urandom_range(0, 3) != 0));
            cycles++;
        end
        chk("T6_budget", 32'(accepted >= 10000), 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
